// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU T-state sequencer.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        StIntSeq,
        StFetch,
        StExec,
        StJam
    } seq_state_t;

    typedef enum logic [1:0] {
        INT_NONE = 2'd0,
        INT_RST  = 2'd1,
        INT_NMI  = 2'd2,
        INT_IRQ  = 2'd3
    } int_kind_t;

    localparam logic [7:0] BRK_OPCODE = 8'h00;
    localparam logic [2:0] T_MAX      = 3'd6;

endpackage

// File: rtl/op_timing_lut.sv
// Per-opcode timing table, decoded from the aaabbbcc opcode fields instead of a literal ROM.
module op_timing_lut (
    input  logic [7:0] opcode,
    output logic [2:0] base_cycles,
    output logic       page_penalty,
    output logic       is_branch,
    output logic       is_jam
);

    logic [2:0] w_aaa;
    logic [2:0] w_bbb;
    logic [1:0] w_cc;
    logic       w_st;
    logic       w_ld;
    logic       w_rmw;

    assign w_aaa = opcode[7:5];
    assign w_bbb = opcode[4:2];
    assign w_cc  = opcode[1:0];
    assign w_st  = (w_aaa == 3'd4);
    assign w_ld  = (w_aaa == 3'd5);
    assign w_rmw = ~w_st & ~w_ld;

    always_comb begin
        base_cycles  = 3'd2;
        page_penalty = 1'b0;
        is_branch    = 1'b0;
        is_jam       = 1'b0;
        unique case (w_cc)
            2'b00: begin
                unique case (w_bbb)
                    3'd0: base_cycles = (w_aaa == 3'd0) ? 3'd7 : (w_aaa <= 3'd3) ? 3'd6 : 3'd2;
                    3'd1: base_cycles = 3'd3;
                    3'd2: base_cycles = (w_aaa > 3'd3) ? 3'd2 : (w_aaa[0] ? 3'd4 : 3'd3);
                    3'd3: base_cycles = (w_aaa == 3'd2) ? 3'd3 : (w_aaa == 3'd3) ? 3'd5 : 3'd4;
                    3'd4: is_branch = 1'b1;
                    3'd5: base_cycles = 3'd4;
                    3'd6: base_cycles = 3'd2;
                    3'd7: begin
                        base_cycles  = w_st ? 3'd5 : 3'd4;
                        page_penalty = ~w_st;
                    end
                endcase
            end
            2'b01: begin
                unique case (w_bbb)
                    3'd0: base_cycles = 3'd6;
                    3'd1: base_cycles = 3'd3;
                    3'd2: base_cycles = 3'd2;
                    3'd3: base_cycles = 3'd4;
                    3'd4: begin
                        base_cycles  = w_st ? 3'd6 : 3'd5;
                        page_penalty = ~w_st;
                    end
                    3'd5: base_cycles = 3'd4;
                    3'd6, 3'd7: begin
                        base_cycles  = w_st ? 3'd5 : 3'd4;
                        page_penalty = ~w_st;
                    end
                endcase
            end
            2'b10: begin
                unique case (w_bbb)
                    3'd0: is_jam = (w_aaa <= 3'd3);
                    3'd1: base_cycles = w_rmw ? 3'd5 : 3'd3;
                    3'd2: base_cycles = 3'd2;
                    3'd3: base_cycles = w_rmw ? 3'd6 : 3'd4;
                    3'd4: is_jam = 1'b1;
                    3'd5: base_cycles = w_rmw ? 3'd6 : 3'd4;
                    3'd6: base_cycles = 3'd2;
                    3'd7: begin
                        base_cycles  = w_rmw ? 3'd7 : (w_st ? 3'd5 : 3'd4);
                        page_penalty = w_ld;
                    end
                endcase
            end
            2'b11: begin
                // 8-cycle illegal RMW forms clamp to 7: t_state cannot go past T6
                unique case (w_bbb)
                    3'd0: base_cycles = w_rmw ? 3'd7 : 3'd6;
                    3'd1: base_cycles = w_rmw ? 3'd5 : 3'd3;
                    3'd2: base_cycles = 3'd2;
                    3'd3: base_cycles = w_rmw ? 3'd6 : 3'd4;
                    3'd4: begin
                        base_cycles  = w_rmw ? 3'd7 : (w_st ? 3'd6 : 3'd5);
                        page_penalty = w_ld;
                    end
                    3'd5: base_cycles = w_rmw ? 3'd6 : 3'd4;
                    3'd6, 3'd7: begin
                        base_cycles  = w_rmw ? 3'd7 : (w_st ? 3'd5 : 3'd4);
                        page_penalty = w_ld;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/cpu_timing_sequencer.sv
// T-state sequencer: opcode fetch strobes, per-instruction cycle counting,
// reset/NMI/IRQ entry sequencing and JAM halt.
module cpu_timing_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_en,
    input  logic [7:0] rd,
    input  logic [7:0] op_in,
    input  logic       page_cross,
    input  logic       branch_taken,
    input  logic       nmi_req,
    input  logic       irq_req,
    input  logic       irq_mask,
    output logic       op_write,
    output logic [7:0] op_wd,
    output logic       sync,
    output logic [2:0] t_state,
    output logic       last_cycle,
    output logic       int_seq,
    output logic [1:0] int_kind,
    output logic       jam
);

    localparam logic [2:0] SEQ_LAST = 3'(RST_CYCLES - 1);

    seq_state_t r_state, w_state_nxt;
    int_kind_t  r_kind, w_kind_nxt;
    logic [2:0] r_t, w_t_nxt;
    logic       r_nmi_pend, w_nmi_pend_nxt;
    logic       r_nmi_prev;

    logic [2:0] w_base;
    logic       w_pen;
    logic       w_br;
    logic       w_jam_op;
    logic       w_nmi_any;
    logic       w_exec_last;
    logic       w_sample;

    op_timing_lut u_lut (
        .opcode      (op_in),
        .base_cycles (w_base),
        .page_penalty(w_pen),
        .is_branch   (w_br),
        .is_jam      (w_jam_op)
    );

    // A same-cycle edge counts as pending so it is taken at this boundary
    assign w_nmi_any      = r_nmi_pend | (nmi_req & ~r_nmi_prev);
    assign w_nmi_pend_nxt = w_sample ? 1'b0 : w_nmi_any;

    always_comb begin
        w_exec_last = 1'b0;
        if (w_br) begin
            case (r_t)
                3'd1:    w_exec_last = ~branch_taken;
                3'd2:    w_exec_last = ~page_cross;
                default: w_exec_last = 1'b1;
            endcase
        end else if (w_pen && (r_t == w_base - 3'd1)) begin
            w_exec_last = ~page_cross;
        end else begin
            w_exec_last = (r_t >= w_base - 3'd1);
        end
        if (r_t == T_MAX) begin
            w_exec_last = 1'b1;
        end
    end

    always_comb begin
        op_write    = 1'b0;
        op_wd       = rd;
        sync        = 1'b0;
        last_cycle  = 1'b0;
        int_seq     = 1'b0;
        jam         = 1'b0;
        w_sample    = 1'b0;
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_kind_nxt  = r_kind;
        unique case (r_state)
            StIntSeq: begin
                int_seq = 1'b1;
                if (r_t == 3'd0 && r_kind != INT_RST) begin
                    op_write = 1'b1;
                    op_wd    = BRK_OPCODE;
                end
                if (r_t == SEQ_LAST) begin
                    last_cycle = 1'b1;
                    if (r_kind == INT_RST) begin
                        w_sample = 1'b1;
                    end else begin
                        w_state_nxt = StFetch;
                        w_t_nxt     = 3'd0;
                        w_kind_nxt  = INT_NONE;
                    end
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            StFetch: begin
                sync        = 1'b1;
                op_write    = 1'b1;
                w_state_nxt = StExec;
                w_t_nxt     = 3'd1;
            end
            StExec: begin
                if (r_t == 3'd1 && w_jam_op) begin
                    jam         = 1'b1;
                    w_state_nxt = StJam;
                end else if (w_exec_last) begin
                    last_cycle = 1'b1;
                    w_sample   = 1'b1;
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            StJam: jam = 1'b1;
        endcase
        if (w_sample) begin
            w_t_nxt = 3'd0;
            if (w_nmi_any) begin
                w_state_nxt = StIntSeq;
                w_kind_nxt  = INT_NMI;
            end else if (irq_req & ~irq_mask) begin
                w_state_nxt = StIntSeq;
                w_kind_nxt  = INT_IRQ;
            end else begin
                w_state_nxt = StFetch;
                w_kind_nxt  = INT_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIntSeq;
            r_t        <= 3'd0;
            r_kind     <= INT_RST;
            r_nmi_pend <= 1'b0;
            r_nmi_prev <= 1'b0;
        end else if (cpu_en) begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_kind     <= w_kind_nxt;
            r_nmi_pend <= w_nmi_pend_nxt;
            r_nmi_prev <= nmi_req;
        end
    end

    assign t_state  = r_t;
    assign int_kind = r_kind;

endmodule

// File: doc/cpu_timing_sequencer.md
Name: cpu_timing_sequencer

Overview:
- Cycle/T-state sequencer for the 6502-compatible CPU core. It sits directly upstream of the opcode register.
- Decides when a new opcode is fetched, and drives that register's write strobe and write data.
- Counts execution T-states for each instruction, using per-opcode timing plus page-cross and branch penalties.
- Sequences the reset, NMI and IRQ entry cycles, and halts on JAM opcodes.

Parameters:
- RST_CYCLES, 7, length of the reset/interrupt entry sequence in cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_en  in  1  CPU clock enable; all state advances only when 1
- rd  in  8  memory read data (opcode byte during fetch)
- op_in  in  8  current opcode register contents
- page_cross  in  1  address unit reports carry into high byte this cycle
- branch_taken  in  1  branch condition true (valid in T1 of a branch)
- nmi_req  in  1  NMI line, active-high level
- irq_req  in  1  IRQ line, active-high level
- irq_mask  in  1  I flag
- op_write  out  1  opcode register write strobe
- op_wd  out  8  opcode register write data
- sync  out  1  opcode fetch cycle marker
- t_state  out  3  current T-state, 0..6
- last_cycle  out  1  final cycle of current instruction or sequence
- int_seq  out  1  reset/interrupt entry sequence active
- int_kind  out  2  0=none 1=RST 2=NMI 3=IRQ
- jam  out  1  CPU halted

Behaviour:
- States:
  - INT_SEQ: entry sequence.
  - FETCH: T0.
  - EXEC: T1..Tn.
  - JAM: halted.
- Register updates are gated by cpu_en. Outputs are combinational from state; consumers qualify strobes with cpu_en.
- Reset (async, any time, including mid-instruction): state=INT_SEQ, t=0, int_kind=RST, pending NMI cleared.
  - op_write=0, sync=0, jam=0, last_cycle=0, int_seq=1, op_wd=rd.
- INT_SEQ:
  - Runs RST_CYCLES cycles, T0..T6.
  - For NMI/IRQ, T0 asserts op_write with op_wd=8'h00 (BRK forced); for RST, op_write=0 throughout.
  - last_cycle is asserted at T6. Next state is FETCH, with int_kind cleared on entering FETCH.
- FETCH (T0): sync=1, op_write=1, op_wd=rd. Next state is EXEC T1. op_in is valid from T1.
- EXEC: instruction cycle count N comes from base_cycles(op_in), 2..7. last_cycle is at T(N-1), unless extended:
  - Page-penalty ops (indexed reads, (zp),Y reads): if page_cross=1 in T(N-1), extend one cycle; the last cycle becomes TN.
  - Branches (N=2):
    - branch_taken=1 in T1 extends to T2.
    - page_cross=1 in T2 extends to T3.
    - branch_taken=0 ends at T1.
  - Other ops ignore page_cross. t_state never exceeds 6.
- JAM opcodes (x2 for x=0..7,9,B,D,F): at T1 enter JAM.
  - jam=1; t_state holds 1; all strobes 0.
  - Interrupts are ignored. Only reset_n exits JAM.
- NMI: rising edge of nmi_req (sampled with cpu_en) sets nmi_pend; it stays set until an NMI INT_SEQ starts.
- Interrupt sampling happens at last_cycle of EXEC, or of INT_SEQ for RST:
  - if nmi_pend, next state is INT_SEQ with kind NMI and nmi_pend is cleared;
  - else if irq_req & ~irq_mask, next state is INT_SEQ with kind IRQ;
  - else next state is FETCH.
- An NMI edge arriving in the same cycle as last_cycle is taken at that boundary.
- irq_mask is sampled at last_cycle only.
- cpu_en=0: state, t, and nmi_pend all hold. The edge detector's previous-value register also holds, so edges are seen across stalls.

Decomposition:
- Package cpu_seq_pkg:
  - seq_state_t enum;
  - int_kind_t enum with constants INT_NONE/RST/NMI/IRQ;
  - BRK_OPCODE=8'h00;
  - T_MAX=6.
- Sub-module op_timing_lut: purely combinational.
  - Input: opcode.
  - Outputs: base_cycles[2:0], page_penalty, is_branch, is_jam.
  - Holds the 256-entry table.

Test Plan:
- Reset: hold reset_n=0, release, rd=8'hA9 after the sequence → int_seq=1, int_kind=RST for 7 cycles, op_write=0. Then T0 has sync=1, op_write=1, op_wd=8'hA9, followed by T1 with last_cycle=1.
- Page penalty: fetch 8'hBD (LDA abs,X) with page_cross=1 at T3 → last_cycle at T4, 5 cycles total. With page_cross=0 → last_cycle at T3.
- Branches: fetch 8'hD0 with branch_taken=1 at T1 and page_cross=1 at T2 → last_cycle at T3, 4 cycles. With branch_taken=0 → 2 cycles.
- IRQ masking:
  - irq_req=1, irq_mask=1 during 8'hEA (NOP) → next state is FETCH.
  - irq_mask=0 → INT_SEQ with int_kind=IRQ, op_write=1 and op_wd=8'h00 at T0, 7 cycles, then FETCH.
- NMI priority: pulse nmi_req for one cycle mid-instruction, with irq_req=1 and mask=0 → next entry is NMI. After it completes, the IRQ is taken at the following instruction boundary.
- JAM and stall:
  - Fetch 8'h02 → jam=1 from T1. It persists for 20 cycles regardless of nmi_req, and is cleared by reset_n.
  - cpu_en=0 for 3 cycles mid-EXEC → t_state is frozen, and the total instruction count is unchanged.
